// File: rtl/cfg_req_xmt.sv
// Config-request BFM: sends one CfgRd0/CfgWr0 at a time as a 1-DW TLP on client0, returns one response; CFG_REQ_TIMEOUT_EN adds a completion timeout.
// Latency: header one cycle after the request handshake, write data one beat later; response one cycle after the deciding completion flag.
// Backpressure: req_ready only in IDLE; xadm_client0_halt freezes the pending beat and every client0 output.
`ifndef DT_WD
`define DT_WD 63
`endif

module cfg_req_xmt #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic               core_clk,
  input  logic               core_rst_n,
  input  logic [15:0]        rc_bdf,
  input  logic [15:0]        ep_bdf,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_wr,
  input  logic [9:0]         req_reg,
  input  logic [3:0]         req_be,
  input  logic [31:0]        req_wdata,
  output logic               client0_tlp_hv,
  output logic               client0_tlp_dv,
  output logic               client0_tlp_eot,
  output logic [`DT_WD:0]    client0_tlp_data,
  output logic [1:0]         client0_tlp_fmt,
  output logic [4:0]         client0_tlp_type,
  output logic [2:0]         client0_tlp_tc,
  output logic [2:0]         client0_tlp_attr,
  output logic [9:0]         client0_tlp_tid,
  output logic [15:0]        client0_req_id,
  output logic               client0_tlp_func_num,
  output logic [63:0]        client0_tlp_addr,
  output logic [12:0]        client0_tlp_byte_len,
  output logic [3:0]         client0_tlp_first_be,
  output logic [3:0]         client0_tlp_last_be,
  output logic               client0_tlp_td,
  output logic               client0_tlp_ep,
  input  logic               xadm_client0_halt,
  input  logic               cpl_flag,
  input  logic               cpl_status,
  input  logic               cpld_flag,
  input  logic               cpld_status,
  input  logic [`DT_WD:0]    cpld_data,
  input  logic [1:0]         cpld_data_vld,
  output logic               rsp_valid,
  output logic [1:0]         rsp_status,
  output logic [31:0]        rsp_rdata
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_HDR       = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_WAIT_CPL  = 3'd3;
  localparam logic [2:0] ST_WAIT_DATA = 3'd4;
  localparam logic [2:0] ST_RESP      = 3'd5;

  localparam logic [1:0] RSP_OK  = 2'b00;
  localparam logic [1:0] RSP_BAD = 2'b01;
  localparam logic [1:0] RSP_TMO = 2'b10;

  localparam logic [4:0] TYPE_CFG0 = 5'b00100;

  typedef struct packed {
    logic        wr;
    logic [9:0]  reg_num;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [15:0] ep_bdf;
    logic [15:0] rc_bdf;
    logic [7:0]  tag;
  } req_t;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  req_t        req_q;
  logic [7:0]  tag_cnt;
  logic [1:0]  rsp_status_q;
  logic [31:0] rsp_rdata_q;

  logic        req_acc;
  logic        hdr_acc;
  logic        dat_acc;
  logic        last_acc;
  logic        waiting;
  logic        tmo_hit;
  logic        wr_ok;
  logic        rd_ok;
  logic        any_flag;

  logic        rsp_set;
  logic [1:0]  rsp_status_nxt;
  logic [31:0] rsp_rdata_nxt;

  assign req_acc  = (state == ST_IDLE) && req_valid;
  assign hdr_acc  = (state == ST_HDR) && !xadm_client0_halt;
  assign dat_acc  = (state == ST_DATA) && !xadm_client0_halt;
  assign last_acc = (hdr_acc && !req_q.wr) || dat_acc;
  assign waiting  = (state == ST_WAIT_CPL) || (state == ST_WAIT_DATA);

  assign wr_ok    = cpl_flag && cpl_status;
  assign rd_ok    = cpld_flag && cpld_status;
  assign any_flag = cpl_flag || cpld_flag;

`ifdef CFG_REQ_TIMEOUT_EN
  localparam logic [16:0] TMO_LAST = 17'(TIMEOUT_CYC - 1);

  // Holds the number of cycles elapsed since the last beat was accepted.
  logic [15:0] tmo_cnt;

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      tmo_cnt <= '0;
    end else if (last_acc) begin
      tmo_cnt <= 16'd1;
    end else if (waiting) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  assign tmo_hit = waiting && ({1'b0, tmo_cnt} >= TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  // A completion flag seen in the expiry cycle takes precedence over the timeout.
  always_comb begin
    state_nxt      = state;
    rsp_set        = 1'b0;
    rsp_status_nxt = RSP_OK;
    rsp_rdata_nxt  = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        if (!xadm_client0_halt) state_nxt = req_q.wr ? ST_DATA : ST_WAIT_CPL;
      end
      ST_DATA: begin
        if (!xadm_client0_halt) state_nxt = ST_WAIT_CPL;
      end
      ST_WAIT_CPL: begin
        if (any_flag) begin
          if (req_q.wr) begin
            rsp_set        = 1'b1;
            rsp_status_nxt = wr_ok ? RSP_OK : RSP_BAD;
            state_nxt      = ST_RESP;
          end else if (rd_ok) begin
            if (cpld_data_vld[0]) begin
              rsp_set       = 1'b1;
              rsp_rdata_nxt = cpld_data[31:0];
              state_nxt     = ST_RESP;
            end else begin
              state_nxt = ST_WAIT_DATA;
            end
          end else begin
            rsp_set        = 1'b1;
            rsp_status_nxt = RSP_BAD;
            state_nxt      = ST_RESP;
          end
        end else if (tmo_hit) begin
          rsp_set        = 1'b1;
          rsp_status_nxt = RSP_TMO;
          state_nxt      = ST_RESP;
        end
      end
      ST_WAIT_DATA: begin
        if (cpld_data_vld[0]) begin
          rsp_set       = 1'b1;
          rsp_rdata_nxt = cpld_data[31:0];
          state_nxt     = ST_RESP;
        end else if (tmo_hit) begin
          rsp_set        = 1'b1;
          rsp_status_nxt = RSP_TMO;
          state_nxt      = ST_RESP;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state        <= ST_IDLE;
      req_q        <= '0;
      tag_cnt      <= '0;
      rsp_status_q <= '0;
      rsp_rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      if (req_acc) begin
        req_q.wr      <= req_wr;
        req_q.reg_num <= req_reg;
        req_q.be      <= req_be;
        req_q.wdata   <= req_wdata;
        req_q.ep_bdf  <= ep_bdf;
        req_q.rc_bdf  <= rc_bdf;
        req_q.tag     <= tag_cnt;
      end
      if (hdr_acc) tag_cnt <= tag_cnt + 8'd1;
      if (rsp_set) begin
        rsp_status_q <= rsp_status_nxt;
        rsp_rdata_q  <= rsp_rdata_nxt;
      end
    end
  end

  // Outputs decode from registered state only, so a halt leaves them frozen.
  assign req_ready            = (state == ST_IDLE);
  assign client0_tlp_hv       = (state == ST_HDR);
  assign client0_tlp_dv       = (state == ST_DATA);
  assign client0_tlp_eot      = (client0_tlp_hv && !req_q.wr) || client0_tlp_dv;
  assign client0_tlp_data     = client0_tlp_dv ? {{(`DT_WD-31){1'b0}}, req_q.wdata} : '0;
  assign client0_tlp_fmt      = (client0_tlp_hv && req_q.wr) ? 2'b10 : 2'b00;
  assign client0_tlp_type     = client0_tlp_hv ? TYPE_CFG0 : 5'b00000;
  assign client0_tlp_tc       = 3'b000;
  assign client0_tlp_attr     = 3'b000;
  assign client0_tlp_tid      = client0_tlp_hv ? {2'b00, req_q.tag} : 10'd0;
  assign client0_req_id       = client0_tlp_hv ? req_q.rc_bdf : 16'd0;
  assign client0_tlp_func_num = 1'b0;
  assign client0_tlp_addr     = client0_tlp_hv ?
                                {32'h0, req_q.ep_bdf, 4'h0, req_q.reg_num, 2'b00} : 64'd0;
  assign client0_tlp_byte_len = client0_tlp_hv ? 13'd4 : 13'd0;
  assign client0_tlp_first_be = client0_tlp_hv ? req_q.be : 4'h0;
  assign client0_tlp_last_be  = 4'h0;
  assign client0_tlp_td       = 1'b0;
  assign client0_tlp_ep       = 1'b0;

  assign rsp_valid  = (state == ST_RESP);
  assign rsp_status = rsp_valid ? rsp_status_q : 2'b00;
  assign rsp_rdata  = rsp_valid ? rsp_rdata_q : 32'd0;

  logic unused_cpld_bits;
  assign unused_cpld_bits = ^{cpld_data[`DT_WD:32], cpld_data_vld[1]};

endmodule

// File: tb/tb_cfg_req_xmt.sv
// Bench for cfg_req_xmt: directed vector table, timeout/reset corner sequences,
// then randomized transactions checked against a transaction-level model.
`ifndef DT_WD
`define DT_WD 63
`endif

module tb_cfg_req_xmt;

  localparam int TMO = 16;
  localparam int K_OK = 0, K_LATE = 1, K_UR = 2, K_BAD = 3;

  logic              core_clk = 1'b0;
  logic              core_rst_n;
  logic [15:0]       rc_bdf, ep_bdf;
  logic              req_valid, req_ready, req_wr;
  logic [9:0]        req_reg;
  logic [3:0]        req_be;
  logic [31:0]       req_wdata;
  logic              client0_tlp_hv, client0_tlp_dv, client0_tlp_eot;
  logic [`DT_WD:0]   client0_tlp_data;
  logic [1:0]        client0_tlp_fmt;
  logic [4:0]        client0_tlp_type;
  logic [2:0]        client0_tlp_tc, client0_tlp_attr;
  logic [9:0]        client0_tlp_tid;
  logic [15:0]       client0_req_id;
  logic              client0_tlp_func_num;
  logic [63:0]       client0_tlp_addr;
  logic [12:0]       client0_tlp_byte_len;
  logic [3:0]        client0_tlp_first_be, client0_tlp_last_be;
  logic              client0_tlp_td, client0_tlp_ep;
  logic              xadm_client0_halt;
  logic              cpl_flag, cpl_status, cpld_flag, cpld_status;
  logic [`DT_WD:0]   cpld_data;
  logic [1:0]        cpld_data_vld;
  logic              rsp_valid;
  logic [1:0]        rsp_status;
  logic [31:0]       rsp_rdata;

  always #5 core_clk = ~core_clk;

  cfg_req_xmt #(.TIMEOUT_CYC(TMO)) dut (
    .core_clk(core_clk), .core_rst_n(core_rst_n),
    .rc_bdf(rc_bdf), .ep_bdf(ep_bdf),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_reg(req_reg), .req_be(req_be), .req_wdata(req_wdata),
    .client0_tlp_hv(client0_tlp_hv), .client0_tlp_dv(client0_tlp_dv),
    .client0_tlp_eot(client0_tlp_eot), .client0_tlp_data(client0_tlp_data),
    .client0_tlp_fmt(client0_tlp_fmt), .client0_tlp_type(client0_tlp_type),
    .client0_tlp_tc(client0_tlp_tc), .client0_tlp_attr(client0_tlp_attr),
    .client0_tlp_tid(client0_tlp_tid), .client0_req_id(client0_req_id),
    .client0_tlp_func_num(client0_tlp_func_num), .client0_tlp_addr(client0_tlp_addr),
    .client0_tlp_byte_len(client0_tlp_byte_len), .client0_tlp_first_be(client0_tlp_first_be),
    .client0_tlp_last_be(client0_tlp_last_be), .client0_tlp_td(client0_tlp_td),
    .client0_tlp_ep(client0_tlp_ep), .xadm_client0_halt(xadm_client0_halt),
    .cpl_flag(cpl_flag), .cpl_status(cpl_status),
    .cpld_flag(cpld_flag), .cpld_status(cpld_status),
    .cpld_data(cpld_data), .cpld_data_vld(cpld_data_vld),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata)
  );

  typedef struct {
    logic        wr;
    logic [9:0]  rg;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [15:0] ep;
    int          nh_hdr;
    int          nh_dat;
    int          kind;
    int          dly;
    logic [31:0] rd;
    logic [1:0]  e_fmt;
    logic [63:0] e_addr;
    logic [1:0]  e_st;
    logic [31:0] e_rd;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  task automatic clear_cpl();
    cpl_flag = 1'b0; cpl_status = 1'b0; cpld_flag = 1'b0; cpld_status = 1'b0;
    cpld_data = '0; cpld_data_vld = 2'b00;
  endtask

  function automatic logic [63:0] cfg_addr(input logic [15:0] ep, input logic [9:0] rg);
    return {32'h0, ep, 4'h0, rg, 2'b00};
  endfunction

  // Handshake one request and walk its header (and data) beat; returns in the first wait cycle.
  task automatic issue(input logic wr, input logic [9:0] rg, input logic [3:0] be,
                       input logic [31:0] wd, input logic [15:0] ep,
                       input int nh_hdr, input int nh_dat,
                       input logic [1:0] e_fmt, input logic [63:0] e_addr);
    chk("req_ready idle", req_ready, 1'b1);
    req_valid = 1'b1; req_wr = wr; req_reg = rg; req_be = be; req_wdata = wd; ep_bdf = ep;
    step();
    req_valid = 1'b0; req_wr = ~wr; req_reg = ~rg; req_be = ~be; req_wdata = ~wd; ep_bdf = ~ep;
    chk("req_ready busy", req_ready, 1'b0);
    for (int i = 0; i <= nh_hdr; i++) begin
      xadm_client0_halt = (i < nh_hdr);
      chk("hdr hv", client0_tlp_hv, 1'b1);
      chk("hdr dv", client0_tlp_dv, 1'b0);
      chk("hdr eot", client0_tlp_eot, !wr);
      chk("hdr fmt", client0_tlp_fmt, e_fmt);
      chk("hdr type", client0_tlp_type, 5'b00100);
      chk("hdr tid", client0_tlp_tid, {2'b00, exp_tag});
      chk("hdr addr", client0_tlp_addr, e_addr);
      chk("hdr first_be", client0_tlp_first_be, be);
      chk("hdr req_id", client0_req_id, 16'hBEEF);
      chk("hdr byte_len", client0_tlp_byte_len, 13'd4);
      chk("hdr zero fields", {client0_tlp_tc, client0_tlp_attr, client0_tlp_last_be,
                              client0_tlp_td, client0_tlp_ep, client0_tlp_func_num}, 64'd0);
      step();
    end
    xadm_client0_halt = 1'b0;
    exp_tag = exp_tag + 8'd1;
    if (wr) begin
      for (int i = 0; i <= nh_dat; i++) begin
        xadm_client0_halt = (i < nh_dat);
        chk("data dv", client0_tlp_dv, 1'b1);
        chk("data hv", client0_tlp_hv, 1'b0);
        chk("data eot", client0_tlp_eot, 1'b1);
        chk("data payload", client0_tlp_data, {32'h0, wd});
        step();
      end
      xadm_client0_halt = 1'b0;
    end
    chk("wait beats idle", {client0_tlp_hv, client0_tlp_dv, client0_tlp_eot}, 3'b000);
  endtask

  // Stall dly cycles, deliver the completion of the given kind, then check the single response.
  task automatic finish_txn(input logic wr, input int kind, input int dly, input logic [31:0] rd,
                            input logic [1:0] e_st, input logic [31:0] e_rd);
    for (int d = 0; d < dly; d++) begin
      cpld_data_vld = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
      chk("wait rsp_valid", rsp_valid, 1'b0);
      chk("wait ready", req_ready, 1'b0);
      step();
    end
    clear_cpl();
    case (kind)
      K_OK: begin
        if (wr) begin
          cpl_flag = 1'b1; cpl_status = 1'b1;
        end else begin
          cpld_flag = 1'b1; cpld_status = 1'b1; cpld_data_vld = 2'b01;
          cpld_data = {{(`DT_WD-31){1'b1}}, rd};
        end
      end
      K_LATE: begin
        cpld_flag = 1'b1; cpld_status = 1'b1;
        step();
        clear_cpl();
        for (int x = 0; x < 2; x++) begin
          cpld_data_vld = 2'b10;
          chk("late rsp_valid", rsp_valid, 1'b0);
          step();
        end
        cpld_data_vld = 2'b11;
        cpld_data = {{(`DT_WD-31){1'b1}}, rd};
      end
      K_UR: begin
        cpl_flag = 1'b1; cpl_status = 1'b0;
      end
      default: begin
        cpld_flag = 1'b1; cpld_status = wr; cpld_data_vld = 2'b01;
        cpld_data = {{(`DT_WD-31){1'b1}}, rd};
      end
    endcase
    step();
    clear_cpl();
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_status", rsp_status, e_st);
    chk("rsp_rdata", rsp_rdata, e_rd);
    step();
    chk("rsp one-shot", rsp_valid, 1'b0);
    chk("req_ready after rsp", req_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    int   k;

    tbl[0] = '{1'b0, 10'h004, 4'hF, 32'h0, 16'h0100, 0, 0, K_OK, 0, 32'h1234_10EE,
               2'b00, 64'h0000_0000_0100_0010, 2'b00, 32'h1234_10EE};
    tbl[1] = '{1'b1, 10'h001, 4'h3, 32'h0000_0006, 16'h0100, 0, 3, K_OK, 2, 32'hFFFF_FFFF,
               2'b10, 64'h0000_0000_0100_0004, 2'b00, 32'h0};
    tbl[2] = '{1'b0, 10'h3FF, 4'h1, 32'h0, 16'hFFFF, 0, 0, K_UR, 1, 32'h5555_AAAA,
               2'b00, 64'h0000_0000_FFFF_0FFC, 2'b01, 32'h0};
    tbl[3] = '{1'b0, 10'h010, 4'hF, 32'h0, 16'h0208, 2, 0, K_LATE, 0, 32'hA5A5_5A5A,
               2'b00, 64'h0000_0000_0208_0040, 2'b00, 32'hA5A5_5A5A};
    tbl[4] = '{1'b1, 10'h2C0, 4'hC, 32'hDEAD_BEEF, 16'h0001, 1, 1, K_BAD, 0, 32'h1357_9BDF,
               2'b10, 64'h0000_0000_0001_0B00, 2'b01, 32'h0};
    tbl[5] = '{1'b0, 10'h080, 4'h8, 32'h0, 16'h0300, 0, 0, K_BAD, 3, 32'h1111_2222,
               2'b00, 64'h0000_0000_0300_0200, 2'b01, 32'h0};
    tbl[6] = '{1'b1, 10'h005, 4'hF, 32'h0, 16'h0000, 0, 0, K_UR, 0, 32'h0,
               2'b10, 64'h0000_0000_0000_0014, 2'b01, 32'h0};

    core_rst_n = 1'b0; rc_bdf = 16'hBEEF; ep_bdf = '0; req_valid = 1'b0; req_wr = 1'b0;
    req_reg = '0; req_be = '0; req_wdata = '0; xadm_client0_halt = 1'b0;
    clear_cpl();
    exp_tag = 8'd0;
    step();
    step();
    chk("reset req_ready", req_ready, 1'b1);
    chk("reset beats", {client0_tlp_hv, client0_tlp_dv, client0_tlp_eot}, 3'b000);
    chk("reset rsp", {rsp_valid, rsp_status, rsp_rdata}, 64'd0);
    chk("reset hdr", {client0_tlp_fmt, client0_tlp_type, client0_tlp_tid, client0_tlp_byte_len}, 64'd0);
    chk("reset addr", client0_tlp_addr, 64'd0);
    chk("reset data", client0_tlp_data, 64'd0);
    core_rst_n = 1'b1;
    step();

    for (int v = 0; v < 7; v++) begin
      issue(tbl[v].wr, tbl[v].rg, tbl[v].be, tbl[v].wd, tbl[v].ep,
            tbl[v].nh_hdr, tbl[v].nh_dat, tbl[v].e_fmt, tbl[v].e_addr);
      finish_txn(tbl[v].wr, tbl[v].kind, tbl[v].dly, tbl[v].rd, tbl[v].e_st, tbl[v].e_rd);
    end

    issue(1'b0, 10'h020, 4'hF, 32'h0, 16'h0400, 0, 0, 2'b00, cfg_addr(16'h0400, 10'h020));
`ifdef CFG_REQ_TIMEOUT_EN
    k = 1;
    while (!rsp_valid && k < 100) begin
      step();
      k++;
    end
    chk("timeout latency", k, TMO);
    chk("timeout status", rsp_status, 2'b10);
    chk("timeout rdata", rsp_rdata, 32'h0);
    step();
    chk("timeout rsp one-shot", rsp_valid, 1'b0);
    chk("timeout ready", req_ready, 1'b1);
`else
    k = 0;
    finish_txn(1'b0, K_UR, 3 * TMO, 32'h0, 2'b01, 32'h0);
`endif

    for (int t = 0; t < 40; t++) begin
      logic        wr;
      logic [9:0]  rg;
      logic [3:0]  be;
      logic [31:0] wd, rd, e_rd;
      logic [15:0] ep;
      logic [1:0]  e_st;
      int          kind;
      wr = ($urandom_range(0, 1) != 0);
      rg = 10'($urandom);
      be = 4'($urandom);
      wd = $urandom;
      rd = $urandom;
      ep = 16'($urandom);
      kind = $urandom_range(0, 3);
      if (wr && kind == K_LATE) kind = K_OK;
      e_st = (kind == K_OK || kind == K_LATE) ? 2'b00 : 2'b01;
      e_rd = (e_st == 2'b00 && !wr) ? rd : 32'h0;
      issue(wr, rg, be, wd, ep, $urandom_range(0, 3), $urandom_range(0, 3),
            wr ? 2'b10 : 2'b00, cfg_addr(ep, rg));
      finish_txn(wr, kind, $urandom_range(0, 6), rd, e_st, e_rd);
    end

    issue(1'b0, 10'h044, 4'hF, 32'h0, 16'h0500, 0, 0, 2'b00, cfg_addr(16'h0500, 10'h044));
    for (int d = 0; d < 3; d++) begin
      chk("pre-reset rsp_valid", rsp_valid, 1'b0);
      step();
    end
    core_rst_n = 1'b0;
    #1;
    chk("mid reset ready", req_ready, 1'b1);
    chk("mid reset rsp_valid", rsp_valid, 1'b0);
    step();
    step();
    core_rst_n = 1'b1;
    exp_tag = 8'd0;
    for (int d = 0; d < 4; d++) begin
      chk("post reset rsp_valid", rsp_valid, 1'b0);
      chk("post reset ready", req_ready, 1'b1);
      step();
    end

    for (int t = 0; t < 257; t++) begin
      logic [9:0]  rg;
      logic [15:0] ep;
      logic [31:0] rd;
      rg = 10'($urandom);
      ep = 16'($urandom);
      rd = $urandom;
      issue(1'b0, rg, 4'hF, 32'h0, ep, $urandom_range(0, 1), 0, 2'b00, cfg_addr(ep, rg));
      finish_txn(1'b0, K_OK, $urandom_range(0, 2), rd, 2'b00, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
